window_scheduler: RTL and testbench
===================================

Name: window_scheduler

Overview:
- Sequences left-channel audio capture into the 8-window sample ring buffer and schedules Hann-window processing of each completed window.
- Sits between the audio CODEC Avalon-ST sources and the ring buffer write port / first_hannifier.
- Issues one go pulse per completed window and tracks downstream busy.
- Holds at most one pending window; when the hannifier falls behind, it drops the oldest pending window and counts the overrun.

Parameters:
- WINDOW_LEN, 1024: samples per window; power of two.
- NUM_WINDOWS, 8: windows held in the ring buffer; power of two.
- DATA_W, 16: sample width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable (level)
- left_in_data  in  16  left sample from CODEC source
- left_in_valid  in  1  left sample valid
- left_in_ready  out  1  left sample ready
- right_in_data  in  16  right sample (discarded)
- right_in_valid  in  1  right sample valid
- right_in_ready  out  1  right sample ready
- ring_buf_data  out  16  write data to ring buffer
- ring_buf_addr  out  13  write address, log2(WINDOW_LEN*NUM_WINDOWS)
- ring_buf_wren  out  1  write strobe
- window_start  out  3  index of the window handed to the hannifier
- go_out  out  1  one-cycle start pulse to first_hannifier
- hann_done  in  1  one-cycle completion pulse from first_hannifier
- overrun_count  out  8  saturating count of dropped windows
- busy  out  1  hannifier is processing a window issued by this block

Behaviour:
- Reset (async, reset_n=0), all outputs 0: ready outputs, ring_buf_*, window_start, go_out, overrun_count, busy. State = IDLE, wr_ptr = 0, pending = 0.
- right_in_ready = 1 in every state except reset, so the right channel drains continuously.
- left_in_ready = 1 in IDLE and RUN, 0 in DRAIN. Samples accepted in IDLE are discarded.
- Accept condition: left_in_valid && left_in_ready.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> IDLE when busy=0 and pending=0.
  - In DRAIN, any pending window is still issued.
- Write path, in RUN only:
  - Each accepted sample produces ring_buf_data = sample, ring_buf_addr = wr_ptr and ring_buf_wren = 1 on the next cycle (latency 1, registered).
  - ring_buf_wren is 0 in every other cycle.
  - wr_ptr increments by 1 and wraps from 8191 to 0.
- Window completion: an accepted sample with wr_ptr[9:0] = 1023 completes window index wr_ptr[12:10].
- Entering RUN resets wr_ptr to 0. A partial window abandoned on RUN->DRAIN is never issued.
- Issue, evaluated each cycle using "free" = (busy=0) or (hann_done=1):
  - If a window completes and the hannifier is free: on the next cycle go_out=1, window_start=index, busy=1.
  - If a window completes while busy and no window is pending: pending=1 and the index is stored.
  - If a window completes while busy and a window is already pending: the stored index is replaced by the new index, and overrun_count increments, saturating at 255.
  - When hann_done occurs and a window is pending: go_out pulses the next cycle with the stored index, and pending clears.
  - When a window completes in the same cycle as hann_done with a window pending: the pending window issues first, and the new window becomes pending.
- hann_done while busy=0 is ignored.
- window_start holds its value between go pulses.
- go_out is never high on two consecutive cycles.
- A reset asserted mid-operation aborts immediately with no further writes. overrun_count clears.

Decomposition:
- Shared package sampler_pkg holds:
  - constants WINDOW_LEN, NUM_WINDOWS, RING_DEPTH, RING_ADDR_W = 13, WIN_IDX_W = 3;
  - typedef enum sched_state_t {IDLE, RUN, DRAIN}.
- Sub-module ring_write_ptr: wrapping write-pointer counter. Inputs: clear and inc. Outputs: ptr and window_done.

Test Plan:
- Reset, then enable=1 and 1024 consecutive valid samples with data = address -> 1024 writes at addr 0..1023 with data 0..1023 at latency 1; go_out pulses once with window_start=0 one cycle after the last write is requested.
- Continuous 8192+1024 samples with hann_done returned 100 cycles after each go -> go sequence of window_start 0,1,...,7,0; address wraps 8191->0; overrun_count=0.
- No hann_done for 3 completed windows -> go for window 0 only; window 2 is issued once hann_done pulses; overrun_count=1.
- hann_done in the same cycle as window 1 completes, with busy from window 0 and nothing pending -> go_out next cycle with window_start=1; busy stays 1.
- enable drops after 500 samples of window 0 -> left_in_ready=0, no go_out, state returns to IDLE; re-enable restarts writes at addr 0.
- reset_n asserted mid-window with busy=1 and a pending window -> all outputs 0 asynchronously; no go_out after release until a new full window completes.

Source files
------------

// File: rtl/window_scheduler_pkg.sv
// Shared constants and types for the audio capture window scheduler.
// Package name is fixed by the surrounding codebase (sampler_pkg).
package sampler_pkg;

  localparam int unsigned WINDOW_LEN  = 1024;
  localparam int unsigned NUM_WINDOWS = 8;
  localparam int unsigned RING_DEPTH  = WINDOW_LEN * NUM_WINDOWS;
  localparam int unsigned RING_ADDR_W = 13;
  localparam int unsigned WIN_IDX_W   = 3;
  localparam int unsigned SAMPLE_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/window_scheduler_if.sv
// CODEC stream inputs, ring-buffer write port and hannifier handshake.
// master = scheduler side, slave = environment side.
interface window_scheduler_if #(
  parameter int unsigned DATA_W = sampler_pkg::SAMPLE_W,
  parameter int unsigned ADDR_W = sampler_pkg::RING_ADDR_W,
  parameter int unsigned IDX_W  = sampler_pkg::WIN_IDX_W
);

  logic              enable;
  logic [DATA_W-1:0] left_in_data;
  logic              left_in_valid;
  logic              left_in_ready;
  logic [DATA_W-1:0] right_in_data;
  logic              right_in_valid;
  logic              right_in_ready;
  logic [DATA_W-1:0] ring_buf_data;
  logic [ADDR_W-1:0] ring_buf_addr;
  logic              ring_buf_wren;
  logic [IDX_W-1:0]  window_start;
  logic              go_out;
  logic              hann_done;
  logic [7:0]        overrun_count;
  logic              busy;

  modport master (
    input  enable, left_in_data, left_in_valid, right_in_data, right_in_valid, hann_done,
    output left_in_ready, right_in_ready, ring_buf_data, ring_buf_addr, ring_buf_wren,
           window_start, go_out, overrun_count, busy
  );

  modport slave (
    output enable, left_in_data, left_in_valid, right_in_data, right_in_valid, hann_done,
    input  left_in_ready, right_in_ready, ring_buf_data, ring_buf_addr, ring_buf_wren,
           window_start, go_out, overrun_count, busy
  );

endinterface

// File: rtl/window_scheduler_ring_write_ptr.sv
// Wrapping ring-buffer write pointer; flags the sample that fills the last
// slot of a window.
module ring_write_ptr #(
  parameter int unsigned WINDOW_LEN  = 1024,
  parameter int unsigned NUM_WINDOWS = 8,
  localparam int unsigned ADDR_W     = $clog2(WINDOW_LEN * NUM_WINDOWS),
  localparam int unsigned LOW_W      = $clog2(WINDOW_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              window_done
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr         = ptr_q;
  assign window_done = inc && !clear && (ptr_q[LOW_W-1:0] == '1);

endmodule

// File: rtl/window_scheduler.sv
// Captures left-channel samples into the windowed ring buffer and issues
// one hannifier start per completed window, keeping at most one pending.
module window_scheduler #(
  parameter int unsigned WINDOW_LEN  = 1024,
  parameter int unsigned NUM_WINDOWS = 8,
  parameter int unsigned DATA_W      = 16
) (
  input logic                clk,
  input logic                reset_n,
  window_scheduler_if.master bus
);
  import sampler_pkg::*;

  localparam int unsigned ADDR_W = $clog2(WINDOW_LEN * NUM_WINDOWS);
  localparam int unsigned LOW_W  = $clog2(WINDOW_LEN);
  localparam int unsigned IDX_W  = ADDR_W - LOW_W;

  sched_state_t      state_q, state_d;
  logic              alive_q, alive_d;
  logic              left_ready, right_ready;
  logic              accept, wr_en, ptr_clear, win_done;
  logic [ADDR_W-1:0] wr_ptr;
  logic [IDX_W-1:0]  win_idx;

  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              go_q, go_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic              busy_q, busy_d;
  logic              pending_q, pending_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              unused_right;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.enable) state_d = RUN;
      RUN:     if (!bus.enable) state_d = DRAIN;
      DRAIN:   if (!busy_q && !pending_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; alive_q keeps both readies low while in reset
  always_comb begin
    left_ready  = alive_q && (state_q != DRAIN);
    right_ready = alive_q;
  end

  assign accept    = bus.left_in_valid && left_ready;
  assign wr_en     = accept && (state_q == RUN);
  assign ptr_clear = (state_q != RUN);
  assign win_idx   = wr_ptr[ADDR_W-1:LOW_W];

  ring_write_ptr #(
    .WINDOW_LEN  (WINDOW_LEN),
    .NUM_WINDOWS (NUM_WINDOWS)
  ) u_wr_ptr (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (ptr_clear),
    .inc         (wr_en),
    .ptr         (wr_ptr),
    .window_done (win_done)
  );

  always_comb begin
    alive_d = 1'b1;
    wren_d  = wr_en;
    addr_d  = addr_q;
    data_d  = data_q;
    if (wr_en) begin
      addr_d = wr_ptr;
      data_d = bus.left_in_data;
    end
  end

  // A pending window takes the freed hannifier before a window completing in
  // the same cycle. Issue is held off one cycle after a go so pulses never
  // abut; the held window then issues from the not-busy path.
  always_comb begin
    busy_d     = busy_q && !bus.hann_done;
    pending_d  = pending_q;
    pend_idx_d = pend_idx_q;
    go_d       = 1'b0;
    start_d    = start_q;
    ovr_d      = ovr_q;
    if (pending_q && !busy_d && !go_q) begin
      go_d      = 1'b1;
      start_d   = pend_idx_q;
      busy_d    = 1'b1;
      pending_d = 1'b0;
    end
    if (win_done) begin
      if (!busy_d && !go_q) begin
        go_d    = 1'b1;
        start_d = win_idx;
        busy_d  = 1'b1;
      end else if (pending_d) begin
        pend_idx_d = win_idx;
        if (ovr_q != '1) ovr_d = ovr_q + 8'd1;
      end else begin
        pending_d  = 1'b1;
        pend_idx_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alive_q    <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      go_q       <= 1'b0;
      start_q    <= '0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      pend_idx_q <= '0;
      ovr_q      <= '0;
    end else begin
      alive_q    <= alive_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      go_q       <= go_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      pend_idx_q <= pend_idx_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.left_in_ready  = left_ready;
  assign bus.right_in_ready = right_ready;
  assign bus.ring_buf_wren  = wren_q;
  assign bus.ring_buf_addr  = addr_q;
  assign bus.ring_buf_data  = data_q;
  assign bus.go_out         = go_q;
  assign bus.window_start   = start_q;
  assign bus.busy           = busy_q;
  assign bus.overrun_count  = ovr_q;

  assign unused_right = ^{bus.right_in_data, bus.right_in_valid};

endmodule

// File: tb/tb_window_scheduler.sv
// Self-checking bench for window_scheduler: scenario table, reset corner case
// and randomized traffic, all compared cycle by cycle against a sample-count model.
`timescale 1ns/1ps
module tb_window_scheduler;

  typedef struct {
    int n1;          // samples written before enable drops
    int n2;          // samples written after re-enable (0 = none)
    int lat;         // hann_done delay after go (-1 = never)
    bit final_done;  // one extra hann_done pulse at the end
    int exp_go;
    int exp_start;
    int exp_ovr;
    int exp_writes;
    int exp_busy;
  } scen_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  window_scheduler_if bus ();

  window_scheduler #(
    .WINDOW_LEN  (1024),
    .NUM_WINDOWS (8),
    .DATA_W      (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_at = -1;
  int lat_mode = -1;
  int n_go, last_start, n_wr;
  bit last_wr;

  // Reference model: mode 0 idle, 1 capturing, 2 draining
  int m_mode, m_cnt, m_start, m_ovr;
  bit m_busy, m_alive;
  int pend_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [63:0] act_pack();
    logic [12:0] a;
    logic [15:0] d;
    a = bus.ring_buf_wren ? bus.ring_buf_addr : 13'd0;
    d = bus.ring_buf_wren ? bus.ring_buf_data : 16'd0;
    return {19'd0, bus.left_in_ready, bus.right_in_ready, bus.ring_buf_wren, a, d,
            bus.go_out, bus.window_start, bus.busy, bus.overrun_count};
  endfunction

  task automatic cycle();
    bit acc, e_wren, e_go, complete, idle_ok;
    int cidx;
    logic [12:0] e_addr;
    logic [15:0] e_data;
    logic [2:0] e_start;
    logic [7:0] e_ovr;
    logic [63:0] e;
    bus.hann_done = (done_at == cyc + 1);
    acc = bus.left_in_valid && m_alive && (m_mode != 2);
    e_wren = acc && (m_mode == 1);
    complete = 1'b0;
    cidx = 0;
    e_addr = '0;
    e_data = '0;
    if (e_wren) begin
      e_addr = 13'(m_cnt % 8192);
      e_data = bus.left_in_data;
      complete = ((m_cnt % 1024) == 1023);
      cidx = (m_cnt / 1024) % 8;
      m_cnt++;
    end
    idle_ok = !m_busy && (pend_q.size() == 0);
    e_go = 1'b0;
    if (bus.hann_done && m_busy) m_busy = 1'b0;
    if (pend_q.size() > 0 && !m_busy) begin
      e_go = 1'b1;
      m_start = pend_q.pop_front();
      m_busy = 1'b1;
    end
    if (complete) begin
      if (!m_busy) begin
        e_go = 1'b1;
        m_start = cidx;
        m_busy = 1'b1;
      end else begin
        if (pend_q.size() > 0) begin
          pend_q.delete();
          if (m_ovr < 255) m_ovr++;
        end
        pend_q.push_back(cidx);
      end
    end
    case (m_mode)
      0: if (bus.enable) begin m_mode = 1; m_cnt = 0; end
      1: if (!bus.enable) m_mode = 2;
      default: if (idle_ok) m_mode = 0;
    endcase
    m_alive = 1'b1;
    e_start = 3'(m_start);
    e_ovr = 8'(m_ovr);
    e = {19'd0, (m_mode != 2), 1'b1, e_wren, e_addr, e_data, e_go, e_start, m_busy, e_ovr};

    @(posedge clk);
    cyc++;
    #1;
    check("cycle_outputs", act_pack(), e);
    if (bus.go_out) begin
      n_go++;
      last_start = int'(bus.window_start);
    end
    if (bus.ring_buf_wren) n_wr++;
    last_wr = e_wren;
    if (e_go) begin
      if (lat_mode >= 0) done_at = cyc + lat_mode;
      else if (lat_mode == -2) done_at = cyc + int'($urandom_range(150, 2500));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.left_in_valid = 1'b0;
    bus.left_in_data = '0;
    bus.right_in_valid = 1'b0;
    bus.right_in_data = '0;
    bus.hann_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", act_pack(), 64'd0);
    m_mode = 0; m_cnt = 0; m_start = 0; m_ovr = 0;
    m_busy = 1'b0; m_alive = 1'b0;
    pend_q.delete();
    done_at = -1;
    n_go = 0; n_wr = 0; last_start = 0;
    reset_n = 1'b1;
  endtask

  task automatic feed(input int n, input bit rnd);
    int got = 0;
    int budget = n * 4 + 20;
    while (got < n && budget > 0) begin
      bus.left_in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.left_in_data = rnd ? 16'($urandom) : 16'(got);
      bus.right_in_valid = 1'($urandom);
      bus.right_in_data = 16'($urandom);
      cycle();
      if (last_wr) got++;
      budget--;
    end
    bus.left_in_valid = 1'b0;
    if (got < n) check("feed_timeout", 64'(got), 64'(n));
  endtask

  task automatic idle(input int k);
    repeat (k) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    scen_t tbl[5];
    tbl[0] = '{1024,    0,  100, 1'b0, 1, 0, 0, 1024, 0};
    tbl[1] = '{9216,    0,  100, 1'b0, 9, 0, 0, 9216, 0};
    tbl[2] = '{3072,    0,   -1, 1'b1, 2, 2, 1, 3072, 1};
    tbl[3] = '{2048,    0, 1024, 1'b0, 2, 1, 0, 2048, 1};
    tbl[4] = '{ 500, 1024,  100, 1'b0, 1, 0, 0, 1524, 0};

    foreach (tbl[i]) begin
      do_reset();
      lat_mode = tbl[i].lat;
      bus.enable = 1'b1;
      feed(tbl[i].n1, 1'b0);
      bus.enable = 1'b0;
      idle(20);
      if (tbl[i].n2 > 0) begin
        bus.enable = 1'b1;
        feed(tbl[i].n2, 1'b0);
        bus.enable = 1'b0;
      end
      idle(300);
      if (tbl[i].final_done) begin
        done_at = cyc + 1;
        idle(5);
      end
      check($sformatf("scen%0d_go_count", i), 64'(n_go), 64'(tbl[i].exp_go));
      check($sformatf("scen%0d_last_start", i), 64'(last_start), 64'(tbl[i].exp_start));
      check($sformatf("scen%0d_overrun", i), 64'(bus.overrun_count), 64'(tbl[i].exp_ovr));
      check($sformatf("scen%0d_writes", i), 64'(n_wr), 64'(tbl[i].exp_writes));
      check($sformatf("scen%0d_busy", i), 64'(bus.busy), 64'(tbl[i].exp_busy));
    end

    // Reset mid-window with window 0 busy and window 1 pending
    do_reset();
    lat_mode = -1;
    bus.enable = 1'b1;
    feed(2548, 1'b0);
    check("busy_before_reset", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", act_pack(), 64'd0);
    do_reset();
    bus.enable = 1'b1;
    feed(1023, 1'b0);
    check("no_go_partial_after_reset", 64'(n_go), 64'd0);
    feed(1, 1'b0);
    idle(2);
    check("go_after_reset", 64'(n_go), 64'd1);
    check("go_after_reset_start", 64'(last_start), 64'd0);

    // Randomized traffic with random hannifier latency and an enable gap
    do_reset();
    lat_mode = -2;
    bus.enable = 1'b1;
    feed(4000, 1'b1);
    bus.enable = 1'b0;
    idle(40);
    bus.enable = 1'b1;
    feed(6000, 1'b1);
    bus.enable = 1'b0;
    idle(5500);
    check("random_final_busy", 64'(bus.busy), 64'd0);
    check("random_final_ready", 64'(bus.left_in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
